// File: rtl/addsub_bist_pkg.sv
// rtl/addsub_bist_pkg.sv - shared constants for the adder/subtractor BIST engine
package addsub_bist_pkg;

    localparam int NUM_VECTORS = 512;
    localparam int VEC_W       = 9;

    // vec = {A[3:0], B[3:0], subtract}
    localparam int A_MSB   = 8;
    localparam int A_LSB   = 5;
    localparam int B_MSB   = 4;
    localparam int B_LSB   = 1;
    localparam int SUB_BIT = 0;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/addsub_golden.sv
// rtl/addsub_golden.sv - combinational reference model of the 4-bit adder/subtractor
module addsub_golden (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       subtract,
    output logic [3:0] exp_result,
    output logic       exp_cout
);

    logic [4:0] sum;

    // Subtract as A + ~B + 1 so Cout = 1 means no borrow
    assign sum = subtract ? ({1'b0, a} + {1'b0, ~b} + 5'd1)
                          : ({1'b0, a} + {1'b0, b});

    assign {exp_cout, exp_result} = sum;

endmodule

// File: rtl/addsub_bist.sv
// rtl/addsub_bist.sv - exhaustive BIST sweep for the adder/subtractor; ADDSUB_BIST_STOP_ON_FAIL_EN stops at first mismatch
module addsub_bist
    import addsub_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dut_result,
    input  logic       dut_cout,
    output logic [3:0] dut_a,
    output logic [3:0] dut_b,
    output logic       dut_subtract,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [8:0] first_fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       exp_result;
    logic             exp_cout;
    logic             mismatch;
    logic             stop_now;

    assign dut_a        = vec[A_MSB:A_LSB];
    assign dut_b        = vec[B_MSB:B_LSB];
    assign dut_subtract = vec[SUB_BIT];

    addsub_golden u_golden (
        .a          (dut_a),
        .b          (dut_b),
        .subtract   (dut_subtract),
        .exp_result (exp_result),
        .exp_cout   (exp_cout)
    );

    assign mismatch = (dut_result != exp_result) || (dut_cout != exp_cout);

`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            vec            <= '0;
            cnt            <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec            <= '0;
                        cnt            <= '0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 10'd1;
                        if (err_count == '0) begin
                            first_fail_vec <= vec;
                        end
                    end
                    // On a stop the vector is left as-is so dut_* still shows the failure
                    if (vec == LAST_VEC || stop_now) begin
                        state <= ST_DONE;
                    end else begin
                        vec   <= vec + VEC_W'(1);
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_WAIT) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_addsub_bist.sv
// tb/tb_addsub_bist.sv - bench for addsub_bist with a behavioural, fault-injectable adder/subtractor
module tb_addsub_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start1, start3;
    logic [3:0] a1, b1, r1, a3, b3, r3;
    logic       s1, c1, s3, c3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [9:0] ec1, ec3;
    logic [8:0] ff1, ff3;

    logic [1:0]   mode;
    logic [511:0] mask;
    int checks = 0;
    int errors = 0;

    function automatic logic [4:0] golden(input int a, input int b, input bit sub);
        int r;
        bit c;
        if (sub) begin
            r = (a - b) & 15;
            c = (a >= b);
        end else begin
            r = (a + b) % 16;
            c = (a + b) > 15;
        end
        return {c, 4'(r)};
    endfunction

    // Device under BIST: mode 0 good, 1 Cout stuck 0, 2 Result[0] inverted, 3 masked random faults
    function automatic logic [4:0] faulty(input logic [3:0] a, input logic [3:0] b, input logic sub,
                                          input logic [1:0] m, input logic [511:0] mk);
        logic [4:0] g;
        int v;
        g = golden(int'(a), int'(b), sub);
        v = int'(a) * 32 + int'(b) * 2 + int'(sub);
        case (m)
            2'd1: g[4] = 1'b0;
            2'd2: g[0] = ~g[0];
            2'd3: if (mk[v]) g = g ^ ((v % 2 == 1) ? 5'b00010 : 5'b10000);
            default: ;
        endcase
        return g;
    endfunction

    assign {c1, r1} = faulty(a1, b1, s1, mode, mask);
    assign {c3, r3} = faulty(a3, b3, s3, mode, mask);

    addsub_bist #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_result(r1), .dut_cout(c1),
        .dut_a(a1), .dut_b(b1), .dut_subtract(s1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(ec1), .first_fail_vec(ff1)
    );

    addsub_bist #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .dut_result(r3), .dut_cout(c3),
        .dut_a(a3), .dut_b(b3), .dut_subtract(s3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(ec3), .first_fail_vec(ff3)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Pulse start, then count edges until done is seen (bounded)
    task automatic run(input bit sel, input bit hammer, output int cyc);
        @(negedge clk);
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        cyc = 0;
        while (!(sel ? done3 : done1) && cyc < 5000) begin
            if (hammer) start3 = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic check_result(input string tag, input bit sel, input int cyc, input int exp_cyc,
                                input int exp_err, input int exp_first, input bit exp_pass);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_err_count"}, int'(sel ? ec3 : ec1), exp_err);
        check({tag, "_pass"}, int'(sel ? pass3 : pass1), int'(exp_pass));
        check({tag, "_busy"}, int'(sel ? busy3 : busy1), 0);
        if (exp_err != 0) check({tag, "_first_fail"}, int'(sel ? ff3 : ff1), exp_first);
    endtask

    // Model-checked sweep: expected values from an independent pass over all 512 vectors
    task automatic sweep_and_check(input string tag, input bit sel, input logic [1:0] m,
                                   input logic [511:0] mk, input bit hammer);
        int n, first, cyc, s, exp_err, exp_cyc, last_vec;
        logic [3:0] a, b;
        logic sub;
        n = 0;
        first = -1;
        mode = m;
        mask = mk;
        for (int v = 0; v < 512; v++) begin
            a = 4'(v / 32);
            b = 4'((v / 2) % 16);
            sub = 1'(v % 2);
            if (faulty(a, b, sub, m, mk) != golden(int'(a), int'(b), sub)) begin
                n++;
                if (first < 0) first = v;
            end
        end
        s = sel ? 3 : 1;
`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
        exp_err  = (n != 0) ? 1 : 0;
        exp_cyc  = ((n != 0) ? first + 1 : 512) * (s + 1);
        last_vec = (n != 0) ? first : 511;
`else
        exp_err  = n;
        exp_cyc  = 512 * (s + 1);
        last_vec = 511;
`endif
        run(sel, hammer, cyc);
        check_result(tag, sel, cyc, exp_cyc, exp_err, first, n == 0);
        check({tag, "_held_vec"}, sel ? int'({a3, b3, s3}) : int'({a1, b1, s1}), last_vec);
    endtask

    typedef struct {
        logic [1:0] mode;
        int         exp_err;
        int         exp_first;
        bit         exp_pass;
        int         exp_cyc;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int cyc;
        logic [511:0] mk;

        tbl[0] = '{2'd0, 0, 0, 1'b1, 1024};
`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
        tbl[1] = '{2'd1, 1, 1, 1'b0, 4};
        tbl[2] = '{2'd2, 1, 0, 1'b0, 2};
`else
        tbl[1] = '{2'd1, 256, 1, 1'b0, 1024};
        tbl[2] = '{2'd2, 512, 0, 1'b0, 1024};
`endif

        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        mode   = 2'd0;
        mask   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs_s1", int'({busy1, done1, pass1, ec1, ff1, a1, b1, s1}), 0);
        check("reset_outputs_s3", int'({busy3, done3, pass3, ec3, ff3, a3, b3, s3}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            mode = tbl[i].mode;
            run(1'b0, 1'b0, cyc);
            check_result($sformatf("table%0d", i), 1'b0, cyc, tbl[i].exp_cyc,
                         tbl[i].exp_err, tbl[i].exp_first, tbl[i].exp_pass);
        end

        // Reset in the middle of the sweep (around vector 200)
        mode = 2'd0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (401) @(negedge clk);
        check("midsweep_busy", int'(busy1), 1);
        check("midsweep_vec", int'({a1, b1, s1}), 200);
        rst_n = 1'b0;
        #1;
        check("midsweep_reset_outputs", int'({busy1, done1, pass1, ec1, ff1, a1, b1, s1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_and_check("after_reset", 1'b0, 2'd0, '0, 1'b0);

        // start hammered while busy must not restart the sweep
        sweep_and_check("hammer_s3", 1'b1, 2'd0, '0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            int dens;
            dens = (r == 0) ? 3 : (r == 1) ? 40 : (r == 2) ? 300 : 2000;
            for (int k = 0; k < 512; k++) mk[k] = ($urandom_range(0, dens) == 0);
            sweep_and_check($sformatf("random%0d", r), 1'($urandom_range(0, 1)), 2'd3, mk, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
